// File: rtl/board_write_sequencer.sv
// Turns an init request or one from/to move into a burst of single-square board writes; special moves gated by BOARD_SEQ_SPECIAL_MOVES_EN.
// Latency accept->done: 2 (from==to), 3 normal/promo, 4 en passant, 5 castle, 65 init; cmd_ready only in IDLE, requests while busy are dropped.
module board_write_sequencer (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [255:0] board_input,
    input  logic         init_req,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [5:0]   cmd_from,
    input  logic [5:0]   cmd_to,
    output logic [5:0]   board_out_addr,
    output logic [3:0]   board_out_piece,
    output logic         board_change_enable,
    output logic         busy,
    output logic         done,
    output logic [1:0]   move_kind
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_init_cnt;
    logic [2:0]  r_idx;
    logic [2:0]  r_cnt;
    logic [5:0]  r_wr_addr [4];
    logic [3:0]  r_wr_dat  [4];
    logic [1:0]  r_kind;

    logic        r_we;
    logic [5:0]  r_addr;
    logic [3:0]  r_piece;
    logic [1:0]  r_move_kind;

    logic [3:0]  w_p;
    logic [5:0]  w_addr [4];
    logic [3:0]  w_dat  [4];
    logic [2:0]  w_cnt;
    logic [1:0]  w_kind;
    logic        w_wr_more;

    function automatic logic [3:0] f_init_piece(input logic [5:0] sq);
        logic [2:0] back;
        logic [3:0] pc;
        case (sq[2:0])
            3'd0, 3'd7: back = 3'd4;
            3'd1, 3'd6: back = 3'd2;
            3'd2, 3'd5: back = 3'd3;
            3'd3:       back = 3'd5;
            default:    back = 3'd6;
        endcase
        case (sq[5:3])
            3'd0:    pc = {1'b1, back};
            3'd1:    pc = 4'b1001;
            3'd6:    pc = 4'b0001;
            3'd7:    pc = {1'b0, back};
            default: pc = 4'b0000;
        endcase
        return pc;
    endfunction

    assign w_p       = board_input[{cmd_from, 2'b00} +: 4];
    assign w_wr_more = (r_idx < r_cnt);

`ifdef BOARD_SEQ_SPECIAL_MOVES_EN
    logic [3:0] w_d;
    logic [2:0] w_fr, w_fc, w_tr, w_tc;
    logic       w_is_castle, w_is_ep, w_is_promo;

    assign w_d         = board_input[{cmd_to, 2'b00} +: 4];
    assign w_fr        = cmd_from[5:3];
    assign w_fc        = cmd_from[2:0];
    assign w_tr        = cmd_to[5:3];
    assign w_tc        = cmd_to[2:0];
    assign w_is_castle = (w_p[2:0] == 3'd6) && (w_fc == 3'd4) && (w_tr == w_fr) &&
                         ((w_tc == 3'd6) || (w_tc == 3'd2));
    assign w_is_ep     = (w_p[2:0] == 3'd1) && (w_fc != w_tc) && (w_d[2:0] == 3'd0);
    assign w_is_promo  = (w_p[2:0] == 3'd1) &&
                         ((!w_p[3] && (w_tr == 3'd0)) || (w_p[3] && (w_tr == 3'd7)));
`endif

    // Full write burst is resolved at accept so later board_input changes cannot leak in.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_addr[i] = '0;
            w_dat[i]  = '0;
        end
        w_cnt     = 3'd0;
        w_kind    = 2'd0;
        w_addr[0] = cmd_to;
        w_dat[0]  = w_p;
        w_addr[1] = cmd_from;
        if (cmd_from != cmd_to) begin
            w_cnt = 3'd2;
`ifdef BOARD_SEQ_SPECIAL_MOVES_EN
            if (w_is_castle) begin
                w_cnt     = 3'd4;
                w_kind    = 2'd1;
                w_addr[2] = {w_fr, (w_tc == 3'd6) ? 3'd7 : 3'd0};
                w_addr[3] = {w_fr, (w_tc == 3'd6) ? 3'd5 : 3'd3};
                w_dat[3]  = {w_p[3], 3'd4};
            end else if (w_is_ep) begin
                w_cnt     = 3'd3;
                w_kind    = 2'd2;
                w_addr[2] = {w_fr, w_tc};
            end else if (w_is_promo) begin
                w_kind    = 2'd3;
                w_dat[0]  = {w_p[3], 3'd5};
            end
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (init_req) begin
                    w_state_nxt = S_INIT;
                end else if (cmd_valid) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_INIT:  if (r_init_cnt == 6'd63) w_state_nxt = S_DONE;
            S_WRITE: if (!w_wr_more) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_init_cnt  <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_kind      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_piece     <= '0;
            r_move_kind <= '0;
            for (int i = 0; i < 4; i++) begin
                r_wr_addr[i] <= '0;
                r_wr_dat[i]  <= '0;
            end
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (init_req) begin
                        r_we       <= 1'b1;
                        r_addr     <= 6'd0;
                        r_piece    <= f_init_piece(6'd0);
                        r_init_cnt <= 6'd0;
                        r_kind     <= 2'd0;
                    end else if (cmd_valid) begin
                        r_wr_addr <= w_addr;
                        r_wr_dat  <= w_dat;
                        r_cnt     <= w_cnt;
                        r_kind    <= w_kind;
                        r_idx     <= 3'd1;
                        if (w_cnt != 3'd0) begin
                            r_we    <= 1'b1;
                            r_addr  <= w_addr[0];
                            r_piece <= w_dat[0];
                        end
                    end
                end
                S_INIT: begin
                    r_init_cnt <= r_init_cnt + 6'd1;
                    if (r_init_cnt != 6'd63) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_init_cnt + 6'd1;
                        r_piece <= f_init_piece(r_init_cnt + 6'd1);
                    end else begin
                        r_move_kind <= r_kind;
                    end
                end
                S_WRITE: begin
                    if (w_wr_more) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_wr_addr[r_idx[1:0]];
                        r_piece <= r_wr_dat[r_idx[1:0]];
                        r_idx   <= r_idx + 3'd1;
                    end else begin
                        r_move_kind <= r_kind;
                    end
                end
                default: ;
            endcase
        end
    end

    assign board_change_enable = r_we;
    assign board_out_addr      = r_addr;
    assign board_out_piece     = r_piece;
    assign move_kind           = r_move_kind;
    assign cmd_ready           = (r_state == S_IDLE);
    assign busy                = (r_state != S_IDLE);
    assign done                = (r_state == S_DONE);

endmodule

// File: tb/tb_board_write_sequencer.sv
// Randomized bench for board_write_sequencer against a rule-level model of the write bursts.
module tb_board_write_sequencer;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [255:0] board_input;
    logic         init_req;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_from;
    logic [5:0]   cmd_to;
    logic [5:0]   board_out_addr;
    logic [3:0]   board_out_piece;
    logic         board_change_enable;
    logic         busy;
    logic         done;
    logic [1:0]   move_kind;

    board_write_sequencer dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .board_input         (board_input),
        .init_req            (init_req),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_from            (cmd_from),
        .cmd_to              (cmd_to),
        .board_out_addr      (board_out_addr),
        .board_out_piece     (board_out_piece),
        .board_change_enable (board_change_enable),
        .busy                (busy),
        .done                (done),
        .move_kind           (move_kind)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] bd [64];
    int exp_n, exp_kind, exp_lat;
    int exp_addr [4];
    int exp_dat  [4];
    int got_addr [8];
    int got_dat  [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] init_sq(input int sq);
        int r, c, back;
        r = sq / 8;
        c = sq % 8;
        case (c)
            0, 7:    back = 4;
            1, 6:    back = 2;
            2, 5:    back = 3;
            3:       back = 5;
            default: back = 6;
        endcase
        if (r == 0) return 4'(8 + back);
        if (r == 1) return 4'd9;
        if (r == 6) return 4'd1;
        if (r == 7) return 4'(back);
        return 4'd0;
    endfunction

    function automatic logic [255:0] pack_board();
        logic [255:0] b;
        for (int i = 0; i < 64; i++) b[i*4 +: 4] = bd[i];
        return b;
    endfunction

    // Expected write list for a move, straight from the chess-level rules.
    task automatic model(input int from, input int to);
        int p;
        p        = int'(bd[from]);
        exp_kind = 0;
        if (from == to) begin
            exp_n   = 0;
            exp_lat = 2;
            return;
        end
        exp_n       = 2;
        exp_lat     = 3;
        exp_addr[0] = to;
        exp_dat[0]  = p;
        exp_addr[1] = from;
        exp_dat[1]  = 0;
`ifdef BOARD_SEQ_SPECIAL_MOVES_EN
        begin
            int fr, fc, tr, tc, pt, pc, dt;
            fr = from / 8; fc = from % 8;
            tr = to / 8;   tc = to % 8;
            pt = p % 8;    pc = p / 8;
            dt = int'(bd[to]) % 8;
            if (pt == 6 && fc == 4 && tr == fr && (tc == 6 || tc == 2)) begin
                exp_n = 4; exp_lat = 5; exp_kind = 1;
                exp_addr[2] = fr * 8 + ((tc == 6) ? 7 : 0);
                exp_dat[2]  = 0;
                exp_addr[3] = fr * 8 + ((tc == 6) ? 5 : 3);
                exp_dat[3]  = pc * 8 + 4;
            end else if (pt == 1 && fc != tc && dt == 0) begin
                exp_n = 3; exp_lat = 4; exp_kind = 2;
                exp_addr[2] = fr * 8 + tc;
                exp_dat[2]  = 0;
            end else if (pt == 1 && ((pc == 0 && tr == 0) || (pc == 1 && tr == 7))) begin
                exp_kind   = 3;
                exp_dat[0] = pc * 8 + 5;
            end
        end
`endif
    endtask

    task automatic run_cmd(input int from, input int to, input bit noisy);
        int got_n, got_lat;
        model(from, to);
        check_eq("ready_before_cmd", cmd_ready, 1);
        board_input = pack_board();
        cmd_from    = 6'(from);
        cmd_to      = 6'(to);
        cmd_valid   = 1'b1;
        @(posedge CLK); #1;
        cmd_valid   = noisy;
        init_req    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        cmd_from    = 6'($urandom);
        board_input = {8{$urandom}};
        check_eq("busy_after_accept", busy, 1);
        got_n   = 0;
        got_lat = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (board_change_enable) begin
                if (got_n < 8) begin
                    got_addr[got_n] = int'(board_out_addr);
                    got_dat[got_n]  = int'(board_out_piece);
                end
                got_n++;
            end
            if (done) begin
                got_lat = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        cmd_valid = 1'b0;
        init_req  = 1'b0;
        check_eq("cmd_latency", got_lat, exp_lat);
        check_eq("cmd_nwrites", got_n, exp_n);
        for (int i = 0; i < exp_n && i < got_n; i++) begin
            check_eq("wr_addr", got_addr[i], exp_addr[i]);
            check_eq("wr_piece", got_dat[i], exp_dat[i]);
        end
        check_eq("move_kind", move_kind, exp_kind);
        if (exp_n > 0) begin
            check_eq("hold_addr", board_out_addr, exp_addr[exp_n-1]);
            check_eq("hold_piece", board_out_piece, exp_dat[exp_n-1]);
        end
        @(posedge CLK); #1;
        check_eq("idle_after_done", busy, 0);
        for (int i = 0; i < exp_n; i++) bd[exp_addr[i]] = 4'(exp_dat[i]);
    endtask

    // abort_at > 0 pulls RESET low in that init cycle.
    task automatic run_init(input int abort_at);
        int got_n, got_lat;
        check_eq("ready_before_init", cmd_ready, 1);
        init_req  = 1'b1;
        cmd_valid = 1'b1;
        cmd_from  = 6'd52;
        cmd_to    = 6'd36;
        @(posedge CLK); #1;
        init_req  = 1'b0;
        cmd_valid = 1'b0;
        got_n   = 0;
        got_lat = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (cyc == abort_at) begin
                check_eq("strobe_before_abort", board_change_enable, 1);
                RESET = 1'b0;
                #1;
                check_eq("abort_strobe", board_change_enable, 0);
                check_eq("abort_ready", cmd_ready, 1);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_addr", board_out_addr, 0);
                check_eq("abort_piece", board_out_piece, 0);
                #2;
                RESET = 1'b1;
                @(posedge CLK); #1;
                check_eq("idle_after_abort", busy, 0);
                return;
            end
            if (board_change_enable) begin
                check_eq("init_addr", board_out_addr, got_n);
                check_eq("init_piece", board_out_piece, init_sq(got_n));
                got_n++;
            end
            if (done) begin
                got_lat = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        check_eq("init_latency", got_lat, 65);
        check_eq("init_nwrites", got_n, 64);
        check_eq("init_kind", move_kind, 0);
        @(posedge CLK); #1;
        check_eq("idle_after_init", busy, 0);
        for (int i = 0; i < 64; i++) bd[i] = init_sq(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET       = 1'b0;
        init_req    = 1'b0;
        cmd_valid   = 1'b0;
        cmd_from    = '0;
        cmd_to      = '0;
        board_input = '0;
        #12;
        check_eq("rst_we", board_change_enable, 0);
        check_eq("rst_addr", board_out_addr, 0);
        check_eq("rst_piece", board_out_piece, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_kind", move_kind, 0);
        check_eq("rst_ready", cmd_ready, 1);
        RESET = 1'b1;
        @(posedge CLK); #1;

        run_init(0);
        run_cmd(52, 36, 1'b0);
        bd[61] = 4'd0;
        bd[62] = 4'd0;
        run_cmd(60, 62, 1'b0);
        bd[28] = 4'b1001;
        bd[27] = 4'b0001;
        bd[20] = 4'b0000;
        run_cmd(27, 20, 1'b0);
        bd[27] = 4'b0001;
        bd[19] = 4'b0000;
        run_cmd(27, 19, 1'b0);
        bd[8] = 4'b0001;
        run_cmd(8, 0, 1'b0);
        run_cmd(10, 10, 1'b0);
        run_init(30);
        run_init(0);

        for (int k = 0; k < 60; k++) begin
            int s, from, to, c, rr, fc, tc;
            for (int i = 0; i < 64; i++)
                bd[i] = ($urandom_range(0, 2) == 0) ?
                        4'($urandom_range(1, 6) + 8 * $urandom_range(0, 1)) : 4'd0;
            s    = $urandom_range(0, 4);
            from = $urandom_range(0, 63);
            to   = $urandom_range(0, 63);
            c    = $urandom_range(0, 1);
            case (s)
                1: begin
                    rr      = $urandom_range(0, 7);
                    from    = rr * 8 + 4;
                    to      = rr * 8 + (($urandom_range(0, 1) == 1) ? 6 : 2);
                    bd[from] = 4'(c * 8 + 6);
                end
                2: begin
                    rr = $urandom_range(1, 6);
                    fc = $urandom_range(0, 7);
                    tc = (fc + $urandom_range(1, 7)) % 8;
                    from = rr * 8 + fc;
                    to   = (rr + ((c == 1) ? 1 : -1)) * 8 + tc;
                    bd[from] = 4'(c * 8 + 1);
                    bd[to]   = ($urandom_range(0, 1) == 1) ? 4'b1000 : 4'b0000;
                end
                3: begin
                    fc   = $urandom_range(0, 7);
                    from = (c == 0) ? 8 + fc : 48 + fc;
                    to   = (c == 0) ? fc : 56 + fc;
                    bd[from] = 4'(c * 8 + 1);
                end
                4: to = from;
                default: ;
            endcase
            run_cmd(from, to, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
